// File: rtl/ddr_init_sequencer.sv
// DDR SDRAM power-up initialisation sequencer.
// Walks the JEDEC-style init sequence: CKE-low power wait, NOP, PRE-all,
// EMRS, MRS with DLL reset, PRE-all, two REFRESH, final MRS, DLL lock wait.
// Each command is held on cmd_* until accepted (cmd_valid & cmd_ready), then
// the per-command delay is timed by a 16-bit down-counter before the next one.
// Build option: define DDR_INIT_FAST_SIM_EN to shorten the power-up wait to
// 16 cycles and the DLL wait to 8 cycles for simulation.
//
// state    | meaning
// IDLE     | waiting for start, CKE low
// PWR_WAIT | power-up wait with CKE low, no commands
// CKE_NOP  | CKE high, NOP issued, then T_RP
// PRE1     | precharge all banks, then T_RP
// EMRS     | extended mode register load, then T_MRD
// MRS_DLL  | mode register load with DLL reset, then T_MRD
// PRE2     | precharge all banks, then T_RP
// REF1     | first auto refresh, then T_RFC
// REF2     | second auto refresh, then T_RFC
// MRS      | mode register load, DLL reset cleared
// DLL_WAIT | DLL lock wait
// DONE     | sequence complete, left only by reset
module ddr_init_sequencer #(
  parameter int unsigned T_INIT  = 60000,
  parameter int unsigned T_RP    = 6,
  parameter int unsigned T_MRD   = 3,
  parameter int unsigned T_RFC   = 24,
  parameter int unsigned T_DLL   = 200,
  parameter logic [12:0] MR_VAL  = 13'h0021,
  parameter logic [12:0] EMR_VAL = 13'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rstn_async,
  input  logic        start,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic [1:0]  cmd_ba,
  output logic [12:0] cmd_addr,
  output logic        cke,
  output logic        busy,
  output logic        init_done
);

`ifdef DDR_INIT_FAST_SIM_EN
  localparam int unsigned INIT_CYC = 16;
  localparam int unsigned DLL_CYC  = 8;
`else
  localparam int unsigned INIT_CYC = T_INIT;
  localparam int unsigned DLL_CYC  = T_DLL;
`endif

  localparam logic [15:0] INIT_LOAD = 16'(INIT_CYC - 1);
  localparam logic [15:0] RP_DLY    = 16'(T_RP);
  localparam logic [15:0] MRD_DLY   = 16'(T_MRD);
  localparam logic [15:0] RFC_DLY   = 16'(T_RFC);
  localparam logic [15:0] DLL_DLY   = 16'(DLL_CYC);

  localparam logic [2:0]  CMD_NOP = 3'b111;
  localparam logic [2:0]  CMD_PRE = 3'b010;
  localparam logic [2:0]  CMD_REF = 3'b001;
  localparam logic [2:0]  CMD_MRS = 3'b000;
  localparam logic [12:0] ADDR_ALL_BANKS = 13'h0400;
  localparam logic [12:0] DLL_RST_BIT    = 13'h0100;

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, CKE_NOP, PRE1, EMRS, MRS_DLL, PRE2, REF1, REF2, MRS,
    DLL_WAIT, DONE
  } state_t;

  state_t      state, state_nx;
  logic        waiting, waiting_nx;
  logic [15:0] cnt, cnt_nx;

  logic        is_cmd;
  logic [2:0]  cmd_c;
  logic [1:0]  ba_c;
  logic [12:0] addr_c;
  logic [15:0] dly;
  state_t      after;

  // State, post-command wait flag and wait counter; reset aborts everything.
  always_ff @(posedge sys_clk or negedge sys_rstn_async) begin
    if (!sys_rstn_async) begin
      state   <= IDLE;
      waiting <= 1'b0;
      cnt     <= 16'd0;
    end else begin
      state   <= state_nx;
      waiting <= waiting_nx;
      cnt     <= cnt_nx;
    end
  end

  // Next-state and output decode. A command state presents its command until
  // it transfers, then times its delay with cmd_valid low. The delay is
  // loaded as T-2 because the transfer cycle and the first valid cycle of the
  // next command bracket the wait; a delay of 1 skips the wait entirely.
  always_comb begin
    state_nx   = state;
    waiting_nx = waiting;
    cnt_nx     = cnt;
    cmd_valid  = 1'b0;
    cmd        = CMD_NOP;
    cmd_ba     = 2'b00;
    cmd_addr   = 13'h0000;
    cke        = 1'b1;
    busy       = 1'b1;
    init_done  = 1'b0;
    is_cmd     = 1'b0;
    cmd_c      = CMD_NOP;
    ba_c       = 2'b00;
    addr_c     = 13'h0000;
    dly        = 16'd1;
    after      = state;

    case (state)
      IDLE: begin
        cke  = 1'b0;
        busy = 1'b0;
        if (start) begin
          state_nx = PWR_WAIT;
          cnt_nx   = INIT_LOAD;
        end
      end
      PWR_WAIT: begin
        cke = 1'b0;
        if (cnt == 16'd0) state_nx = CKE_NOP;
        else              cnt_nx   = cnt - 16'd1;
      end
      CKE_NOP: begin
        is_cmd = 1'b1; dly = RP_DLY;  after = PRE1;
      end
      PRE1: begin
        is_cmd = 1'b1; dly = RP_DLY;  after = EMRS;
        cmd_c  = CMD_PRE; addr_c = ADDR_ALL_BANKS;
      end
      EMRS: begin
        is_cmd = 1'b1; dly = MRD_DLY; after = MRS_DLL;
        cmd_c  = CMD_MRS; ba_c = 2'b01; addr_c = EMR_VAL;
      end
      MRS_DLL: begin
        is_cmd = 1'b1; dly = MRD_DLY; after = PRE2;
        cmd_c  = CMD_MRS; addr_c = MR_VAL | DLL_RST_BIT;
      end
      PRE2: begin
        is_cmd = 1'b1; dly = RP_DLY;  after = REF1;
        cmd_c  = CMD_PRE; addr_c = ADDR_ALL_BANKS;
      end
      REF1: begin
        is_cmd = 1'b1; dly = RFC_DLY; after = REF2;
        cmd_c  = CMD_REF;
      end
      REF2: begin
        is_cmd = 1'b1; dly = RFC_DLY; after = MRS;
        cmd_c  = CMD_REF;
      end
      MRS: begin
        is_cmd = 1'b1; dly = DLL_DLY; after = DONE;
        cmd_c  = CMD_MRS; addr_c = MR_VAL & ~DLL_RST_BIT;
      end
      DLL_WAIT: begin
        if (cnt == 16'd0) state_nx = DONE;
        else              cnt_nx   = cnt - 16'd1;
      end
      DONE: begin
        busy      = 1'b0;
        init_done = 1'b1;
      end
      default: begin
        cke      = 1'b0;
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase

    if (is_cmd) begin
      if (waiting) begin
        if (cnt == 16'd0) begin
          state_nx   = after;
          waiting_nx = 1'b0;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end else begin
        cmd_valid = 1'b1;
        cmd       = cmd_c;
        cmd_ba    = ba_c;
        cmd_addr  = addr_c;
        if (cmd_ready) begin
          if (dly == 16'd1) begin
            state_nx = after;
          end else begin
            cnt_nx = dly - 16'd2;
            // The DLL lock wait after the final MRS has its own state.
            if (state == MRS) state_nx   = DLL_WAIT;
            else              waiting_nx = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Testbench for ddr_init_sequencer: a short-timing instance and a
// default-parameter instance, checked against an event-level reference model.
module tb_ddr_init_sequencer;
  localparam int MAXL = 60320;
  localparam int S    = 3;

  typedef struct packed {
    logic        v;
    logic [2:0]  c;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        cke;
    logic        busy;
    logic        done;
  } smp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  c;
    logic [1:0]  ba;
    logic [12:0] a;
  } xfer_t;

  localparam smp_t RST_EXP = '{v:1'b0, c:3'b111, ba:2'b00, a:13'h0000,
                               cke:1'b0, busy:1'b0, done:1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_f, start_f, ready_f, valid_f, cke_f, busy_f, done_f;
  logic [2:0]  cmd_f;
  logic [1:0]  ba_f;
  logic [12:0] addr_f;
  logic        rstn_d, start_d, ready_d, valid_d, cke_d, busy_d, done_d;
  logic [2:0]  cmd_d;
  logic [1:0]  ba_d;
  logic [12:0] addr_d;
  smp_t        smp_f, smp_d;

  assign smp_f = {valid_f, cmd_f, ba_f, addr_f, cke_f, busy_f, done_f};
  assign smp_d = {valid_d, cmd_d, ba_d, addr_d, cke_d, busy_d, done_d};

  ddr_init_sequencer #(.T_INIT(16), .T_RP(1), .T_MRD(3), .T_RFC(5), .T_DLL(8)) dut_f (
    .sys_clk(clk), .sys_rstn_async(rstn_f), .start(start_f), .cmd_ready(ready_f),
    .cmd_valid(valid_f), .cmd(cmd_f), .cmd_ba(ba_f), .cmd_addr(addr_f),
    .cke(cke_f), .busy(busy_f), .init_done(done_f));

  ddr_init_sequencer dut_d (
    .sys_clk(clk), .sys_rstn_async(rstn_d), .start(start_d), .cmd_ready(ready_d),
    .cmd_valid(valid_d), .cmd(cmd_d), .cmd_ba(ba_d), .cmd_addr(addr_d),
    .cke(cke_d), .busy(busy_d), .init_done(done_d));

  int checks = 0;
  int failures = 0;

  bit    s_pat [MAXL];
  bit    r_pat [MAXL];
  bit    x_pat [MAXL];
  smp_t  tr    [MAXL];
  xfer_t exp_q[$];
  xfer_t obs_q[$];
  int    exp_done, exp_cke, obs_done, obs_cke;

  // Fresh patterns: reset in cycles 0-1, ready high, one start in cycle S.
  task automatic prep();
    for (int i = 0; i < MAXL; i++) begin
      s_pat[i] = 1'b0; r_pat[i] = 1'b1; x_pat[i] = 1'b0;
    end
    x_pat[0] = 1'b1; x_pat[1] = 1'b1; s_pat[S] = 1'b1;
  endtask

  // Drive one cycle per pattern index and record outputs mid-cycle.
  task automatic run(input bit sel, input int len);
    @(posedge clk); #1;
    for (int i = 0; i < len; i++) begin
      if (sel) begin
        rstn_d = !x_pat[i]; start_d = s_pat[i]; ready_d = r_pat[i];
      end else begin
        rstn_f = !x_pat[i]; start_f = s_pat[i]; ready_f = r_pat[i];
      end
      @(negedge clk);
      tr[i] = sel ? smp_d : smp_f;
      @(posedge clk); #1;
    end
    start_d = 1'b0; start_f = 1'b0;
  endtask

  // Reference: find each start, wait T_INIT, then walk the eight commands,
  // each transferring at the first ready cycle and spacing the next one by
  // its delay; a reset cycle aborts the run and starts are ignored until it.
  task automatic model(input int len, input int ti, input int rp, input int mrd,
                       input int rfc, input int dll);
    logic [2:0]  kc [8];
    logic [1:0]  kb [8];
    logic [12:0] ka [8];
    int          kd [8];
    int pos, st, rr, v, ci;
    bit ab;
    kc = '{3'b111, 3'b010, 3'b000, 3'b000, 3'b010, 3'b001, 3'b001, 3'b000};
    kb = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    ka = '{13'h000, 13'h400, 13'h000, 13'h121, 13'h400, 13'h000, 13'h000, 13'h021};
    kd = '{rp, rp, mrd, mrd, rp, rfc, rfc, dll};
    exp_q.delete(); exp_done = -1; exp_cke = -1; pos = 0;
    while (pos < len) begin
      st = pos;
      while (st < len && !(s_pat[st] && !x_pat[st])) st++;
      if (st >= len) break;
      rr = st + 1;
      while (rr < len && !x_pat[rr]) rr++;
      v  = st + 1 + ti;
      ab = (v >= rr);
      if (!ab && exp_cke < 0) exp_cke = v;
      for (int k = 0; k < 8 && !ab; k++) begin
        ci = v;
        while (ci < rr && !r_pat[ci]) ci++;
        if (ci >= rr) ab = 1'b1;
        else begin
          exp_q.push_back('{32'(ci), kc[k], kb[k], ka[k]});
          v = ci + kd[k];
        end
      end
      if (!ab && v < rr && exp_done < 0) exp_done = v;
      pos = rr;
    end
  endtask

  task automatic extract(input int len);
    obs_q.delete(); obs_done = -1; obs_cke = -1;
    for (int i = 0; i < len; i++) begin
      if (tr[i].v && r_pat[i] && !x_pat[i])
        obs_q.push_back('{32'(i), tr[i].c, tr[i].ba, tr[i].a});
      if (tr[i].done === 1'b1 && obs_done < 0) obs_done = i;
      if (tr[i].cke === 1'b1 && obs_cke < 0) obs_cke = i;
    end
  endtask

  task automatic test_reset();
    rstn_f = 1'b0; rstn_d = 1'b0; start_f = 1'b0; start_d = 1'b0;
    ready_f = 1'b1; ready_d = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (smp_f !== RST_EXP) begin failures++; $display("FAIL reset_f got %h exp %h", smp_f, RST_EXP); end
    checks++;
    if (smp_d !== RST_EXP) begin failures++; $display("FAIL reset_d got %h exp %h", smp_d, RST_EXP); end
    @(posedge clk); #1; rstn_f = 1'b1; rstn_d = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (smp_f !== RST_EXP) begin failures++; $display("FAIL idle_no_start got %h exp %h", smp_f, RST_EXP); end
  endtask

  task automatic test_fast_sequence();
    int t;
    prep();
    run(0, 100);
    model(100, 16, 1, 3, 5, 8);
    extract(100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL seq_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++;
        $display("FAIL seq_xfer%0d got cyc=%0d cmd=%b ba=%0d addr=%h exp cyc=%0d cmd=%b ba=%0d addr=%h", k,
                 obs_q[k].cyc, obs_q[k].c, obs_q[k].ba, obs_q[k].a, exp_q[k].cyc, exp_q[k].c, exp_q[k].ba, exp_q[k].a); end
    end
    checks++;
    if (obs_done != S + 44) begin failures++; $display("FAIL seq_done got %0d exp %0d", obs_done, S + 44); end
    checks++;
    if (tr[S].busy !== 1'b0 || tr[S+1].busy !== 1'b1 || tr[S+44].busy !== 1'b0) begin failures++;
      $display("FAIL seq_busy got %b%b%b exp 010", tr[S].busy, tr[S+1].busy, tr[S+44].busy); end
    checks++;
    if (obs_q.size() > 4) begin
      t = int'(obs_q[4].cyc);
      if (tr[t+1].v !== 1'b1 || tr[t+1].c !== 3'b001) begin failures++;
        $display("FAIL rp1_ref1 got v=%b cmd=%b exp v=1 cmd=001", tr[t+1].v, tr[t+1].c); end
    end else begin failures++; $display("FAIL rp1_ref1 got %0d transfers exp 8", obs_q.size()); end
  endtask

  task automatic test_random_ready();
    int idle_bad, stall_bad;
    for (int rep = 0; rep < 3; rep++) begin
      prep();
      for (int i = S + 10; i < 200; i++) r_pat[i] = ($urandom_range(0, 2) != 0);
      run(0, 260);
      model(260, 16, 1, 3, 5, 8);
      extract(260);
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[k]) if (k < obs_q.size()) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin failures++;
          $display("FAIL rnd_xfer%0d got cyc=%0d cmd=%b addr=%h exp cyc=%0d cmd=%b addr=%h", k,
                   obs_q[k].cyc, obs_q[k].c, obs_q[k].a, exp_q[k].cyc, exp_q[k].c, exp_q[k].a); end
      end
      checks++;
      if (obs_done != exp_done) begin failures++; $display("FAIL rnd_done got %0d exp %0d", obs_done, exp_done); end
      idle_bad = 0; stall_bad = 0;
      for (int i = 0; i < 259; i++) begin
        if (!tr[i].v && (tr[i].c !== 3'b111 || tr[i].ba !== 2'b00 || tr[i].a !== 13'h0)) idle_bad++;
        if (tr[i].v && !r_pat[i] && !x_pat[i+1] &&
            (tr[i+1].v !== 1'b1 || tr[i+1].c !== tr[i].c || tr[i+1].ba !== tr[i].ba || tr[i+1].a !== tr[i].a)) stall_bad++;
      end
      checks++;
      if (idle_bad != 0) begin failures++; $display("FAIL rnd_idle_nop got %0d bad cycles exp 0", idle_bad); end
      checks++;
      if (stall_bad != 0) begin failures++; $display("FAIL rnd_stall_hold got %0d bad cycles exp 0", stall_bad); end
    end
  endtask

  task automatic test_stall();
    int bad;
    prep();
    for (int i = S + 19; i < S + 69; i++) r_pat[i] = 1'b0;
    run(0, 160);
    model(160, 16, 1, 3, 5, 8);
    extract(160);
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++;
        $display("FAIL stall_xfer%0d got cyc=%0d cmd=%b addr=%h exp cyc=%0d cmd=%b addr=%h", k,
                 obs_q[k].cyc, obs_q[k].c, obs_q[k].a, exp_q[k].cyc, exp_q[k].c, exp_q[k].a); end
    end
    bad = 0;
    for (int i = S + 19; i < S + 69; i++)
      if (tr[i].v !== 1'b1 || tr[i].c !== 3'b000 || tr[i].ba !== 2'b01 || tr[i].a !== 13'h000) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stall_emrs_hold got %0d bad cycles exp 0", bad); end
    checks++;
    if (tr[S+71].v !== 1'b0 || tr[S+72].v !== 1'b1 || tr[S+72].a !== 13'h121) begin failures++;
      $display("FAIL stall_mrd got v71=%b v72=%b addr=%h exp 0 1 121", tr[S+71].v, tr[S+72].v, tr[S+72].a); end
  endtask

  task automatic test_reset_mid();
    prep();
    x_pat[S+26] = 1'b1;
    s_pat[S+30] = 1'b1;
    run(0, 120);
    model(120, 16, 1, 3, 5, 8);
    extract(120);
    checks++;
    if (tr[S+25].cke !== 1'b1) begin failures++; $display("FAIL rmid_cke_before got %b exp 1", tr[S+25].cke); end
    checks++;
    if (tr[S+26] !== RST_EXP) begin failures++; $display("FAIL rmid_clear got %h exp %h", tr[S+26], RST_EXP); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rmid_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++;
        $display("FAIL rmid_xfer%0d got cyc=%0d cmd=%b addr=%h exp cyc=%0d cmd=%b addr=%h", k,
                 obs_q[k].cyc, obs_q[k].c, obs_q[k].a, exp_q[k].cyc, exp_q[k].c, exp_q[k].a); end
    end
    checks++;
    if (obs_done != S + 74) begin failures++; $display("FAIL rmid_done got %0d exp %0d", obs_done, S + 74); end
  endtask

  task automatic test_ignore_start();
    prep();
    s_pat[S+5] = 1'b1;
    s_pat[S+60] = 1'b1;
    s_pat[S+61] = 1'b1;
    run(0, 100);
    model(100, 16, 1, 3, 5, 8);
    extract(100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ign_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++;
        $display("FAIL ign_xfer%0d got cyc=%0d cmd=%b exp cyc=%0d cmd=%b", k, obs_q[k].cyc, obs_q[k].c, exp_q[k].cyc, exp_q[k].c); end
    end
    checks++;
    if (obs_done != S + 44) begin failures++; $display("FAIL ign_done got %0d exp %0d", obs_done, S + 44); end
    checks++;
    if (tr[99].done !== 1'b1 || tr[99].busy !== 1'b0 || tr[99].cke !== 1'b1 || tr[99].v !== 1'b0) begin failures++;
      $display("FAIL ign_sticky got done=%b busy=%b cke=%b v=%b exp 1 0 1 0", tr[99].done, tr[99].busy, tr[99].cke, tr[99].v); end
  endtask

  task automatic test_default_timing();
    prep();
    run(1, 60300);
    model(60300, 60000, 6, 3, 24, 200);
    extract(60300);
    checks++;
    if (obs_cke != S + 1 + 60000) begin failures++; $display("FAIL def_cke got %0d exp %0d", obs_cke, S + 1 + 60000); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL def_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin failures++;
        $display("FAIL def_xfer%0d got cyc=%0d cmd=%b addr=%h exp cyc=%0d cmd=%b addr=%h", k,
                 obs_q[k].cyc, obs_q[k].c, obs_q[k].a, exp_q[k].cyc, exp_q[k].c, exp_q[k].a); end
    end
    checks++;
    if (obs_q.size() < 7) begin failures++; $display("FAIL def_ref_spacing got %0d transfers exp 8", obs_q.size()); end
    else if (obs_q[6].cyc - obs_q[5].cyc != 32'd24) begin failures++;
      $display("FAIL def_ref_spacing got %0d exp 24", obs_q[6].cyc - obs_q[5].cyc); end
    checks++;
    if (obs_done != S + 60273) begin failures++; $display("FAIL def_done got %0d exp %0d", obs_done, S + 60273); end
  endtask

  initial begin
    test_reset();
    test_fast_sequence();
    test_random_ready();
    test_stall();
    test_reset_mid();
    test_ignore_start();
    test_default_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
